// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and frame constants.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on rd_data without a pop.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic                  pop_ok, push_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign count   = wptr - rptr;
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok = push & (~full | pop_ok);
  // Storage is never reset; gating keeps the head at zero while nothing is held.
  assign rd_data = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, frame FSM with watchdog,
// and a show-ahead byte FIFO with sticky error flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_DEPTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [7:0]            rd_data,
  output logic                  out_valid,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int                      WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]         WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]              LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]   clk_sync, data_sync;
  logic                     clk_prev, fall, bit_in;
  ps2_state_e               state;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift_reg, push_byte;
  logic                     par_ok, push_q;
  logic [WD_W-1:0]          wd_cnt;
  logic                     empty, pop_req;

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in  = data_sync[SYNC_STAGES-1];
  assign pop_req = rd_en & ~empty;

  // Synchronise both pins; resets to the idle-high bus level so release makes no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM, watchdog and parity/frame error flags; a new error beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_ok     <= 1'b0;
      wd_cnt     <= '0;
      push_q     <= 1'b0;
      push_byte  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (clr_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (state == IDLE || fall) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 1'b1;

      if (state != IDLE && !fall && wd_cnt == WD_MAX) begin
        // Device stalled mid-frame: abandon the partial byte.
        state     <= IDLE;
        shift_reg <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shift_reg <= {bit_in, shift_reg[PS2_DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shift_reg, bit_in};
            state  <= STOP;
          end
          STOP: begin
            if (!bit_in)      frame_err  <= 1'b1;
            else if (!par_ok) parity_err <= 1'b1;
            else begin
              push_q    <= 1'b1;
              push_byte <= shift_reg;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sticky overflow: a good byte arrived with no room and no simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             overflow <= 1'b0;
    else if (push_q && full && !pop_req) overflow <= 1'b1;
    else if (clr_err)                    overflow <= 1'b0;
  end

  sync_fifo #(
    .DATA_WIDTH (PS2_DATA_BITS),
    .DATA_DEPTH (DATA_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wr_data (push_byte),
    .pop     (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign out_valid = ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single-frame vectors plus
// hand sequences for overflow, full-with-pop, watchdog and mid-frame reset.
module tb_ps2_rx_fifo;

  localparam int TO = 5000;

  logic       clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, rd_en = 0, clr_err = 0;
  logic [7:0] rd_data;
  logic       out_valid, full, overflow, parity_err, frame_err;
  logic [3:0] count;
  int         checks = 0, errors = 0;

  ps2_rx_fifo #(.DATA_DEPTH(8), .ADDR_WIDTH(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .out_valid(out_valid), .full(full),
    .count(count), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data; bit flip; bit stop; bit pop; bit clr;
    bit exp_valid; logic [7:0] exp_data; int exp_cnt; bit exp_pe; bit exp_fe;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit flip, input bit stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  // Device drives data while clock is high, then a 6/6-cycle clock pulse per bit.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (6) @(posedge clk);
      #1 ps2_clk = 0;
      if (pop_at_stop && i == 10) begin
        // Stop edge is acted on 3 edges later; push reaches the FIFO on the 4th.
        repeat (3) @(posedge clk);
        #1 rd_en = 1;
        @(posedge clk); #1 rd_en = 0;
        repeat (2) @(posedge clk);
      end else begin
        repeat (6) @(posedge clk);
      end
      #1 ps2_clk = 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop, input bit pop_at_stop);
    send_bits(mk(b, flip, stop), 11, pop_at_stop);
    #1 ps2_data = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop1();
    @(posedge clk); #1 rd_en = 1;
    @(posedge clk); #1 rd_en = 0;
    @(negedge clk);
  endtask

  task automatic clear_errs();
    @(posedge clk); #1 clr_err = 1;
    @(posedge clk); #1 clr_err = 0;
    @(negedge clk);
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_data", int'(rd_data), int'(first) + i);
      pop1();
    end
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 1, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_flags", int'({full, overflow, parity_err, frame_err}), 0);
    chk("rst_data", int'(rd_data), 0);
    @(posedge clk); #1 rst = 0;

    // Single-frame vectors
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].data, vecs[v].flip, vecs[v].stop, 1'b0);
      chk($sformatf("v%0d_valid", v), int'(out_valid), int'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk($sformatf("v%0d_data", v), int'(rd_data), int'(vecs[v].exp_data));
      chk($sformatf("v%0d_count", v), int'(count), vecs[v].exp_cnt);
      chk($sformatf("v%0d_perr", v), int'(parity_err), int'(vecs[v].exp_pe));
      chk($sformatf("v%0d_ferr", v), int'(frame_err), int'(vecs[v].exp_fe));
      chk($sformatf("v%0d_ovf", v), int'(overflow), 0);
      if (vecs[v].pop) begin
        pop1();
        chk($sformatf("v%0d_pop_valid", v), int'(out_valid), 0);
        chk($sformatf("v%0d_pop_count", v), int'(count), 0);
      end
      if (vecs[v].clr) begin
        clear_errs();
        chk($sformatf("v%0d_clr_flags", v), int'({overflow, parity_err, frame_err}), 0);
      end
    end

    // Overflow: nine frames, no reads
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      if (i == 7) chk("ovf_full_at7", int'(full), 0);
    end
    chk("ovf_full_at8", int'(full), 1);
    chk("ovf_count_at8", int'(count), 8);
    chk("ovf_flag_at8", int'(overflow), 0);
    send_frame(8'h09, 1'b0, 1'b1, 1'b0);
    chk("ovf_flag_at9", int'(overflow), 1);
    chk("ovf_count_at9", int'(count), 8);
    drain(8'h01, 8);
    chk("ovf_drained", int'(out_valid), 0);
    clear_errs();
    chk("ovf_cleared", int'(overflow), 0);

    // Full with simultaneous pop on the push cycle
    for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b0, 1'b1, 1'b0);
    chk("fp_full", int'(full), 1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    chk("fp_count", int'(count), 8);
    chk("fp_ovf", int'(overflow), 0);
    drain(8'h22, 7);
    chk("fp_last_data", int'(rd_data), 'h33);
    pop1();
    chk("fp_empty", int'(out_valid), 0);

    // Watchdog: start + 4 data bits, then the clock stops
    send_bits(mk(8'hA5, 1'b0, 1'b1), 5, 1'b0);
    #1 ps2_data = 1;
    // send_bits returned 6 edges after the last pin fall; flag due at fall + 3 + TO edges.
    repeat (3 + TO - 1 - 6) @(posedge clk);
    @(negedge clk);
    chk("wd_before", int'(frame_err), 0);
    @(negedge clk);
    chk("wd_at_timeout", int'(frame_err), 1);
    chk("wd_no_push", int'(count), 0);
    clear_errs();
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    chk("wd_next_data", int'(rd_data), 'h12);
    chk("wd_next_count", int'(count), 1);
    chk("wd_next_ferr", int'(frame_err), 0);

    // Mid-frame reset with data and a flag already present
    send_frame(8'h77, 1'b1, 1'b1, 1'b0);
    chk("mr_pre_perr", int'(parity_err), 1);
    send_bits(mk(8'h3C, 1'b0, 1'b1), 4, 1'b0);
    #3 rst = 1;
    @(negedge clk);
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_count", int'(count), 0);
    chk("mr_flags", int'({full, overflow, parity_err, frame_err}), 0);
    chk("mr_data", int'(rd_data), 0);
    @(posedge clk); #1 rst = 0; ps2_data = 1;
    repeat (4) @(posedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    chk("mr_next_data", int'(rd_data), 'h12);
    chk("mr_next_count", int'(count), 1);
    chk("mr_next_flags", int'({overflow, parity_err, frame_err}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a buffered byte output. It synchronises the raw `ps2_clk`/`ps2_data` pins and decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Good bytes go into a show-ahead FIFO; bad frames are dropped, with sticky error flags and a frame watchdog. It sits between the board GPIO/PS/2 pins and the keyboard scan-code consumer (7-seg display path, later a CPU-mapped peripheral).

## Interface
- `DATA_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_WIDTH`, 3: log2(`DATA_DEPTH`).
- `SYNC_STAGES`, 2: synchroniser flops on each PS/2 line; ≥2.
- `TIMEOUT_CYCLES`, 5000: `clk` cycles without a `ps2_clk` falling edge mid-frame before the frame is aborted; ≥16.
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `rd_en` in 1: pop the head byte. Ignored when `out_valid`=0.
- `clr_err` in 1: one-cycle pulse that clears all sticky error flags.
- `rd_data` out 8: head byte. Valid while `out_valid`=1.
- `out_valid` out 1: FIFO not empty.
- `full` out 1: FIFO holds `DATA_DEPTH` bytes.
- `count` out `ADDR_WIDTH`+1: current occupancy.
- `overflow` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `parity_err` out 1: sticky; set when a frame fails odd parity.
- `frame_err` out 1: sticky; set on a bad stop bit or a watchdog timeout.

## Operation
- **Synchroniser:** each pin passes through `SYNC_STAGES` flops. A falling edge is detected when the previous synced `ps2_clk` is 1 and the current one is 0. Data is sampled from synced `ps2_data` in that same cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. Transitions happen only on a detected falling edge, except for the timeout.
  - IDLE: if data=0 (start bit), go to DATA and clear the bit counter. If data=1, stay in IDLE and set no flag.
  - DATA: shift the bit into bit 7 of an 8-bit shift register (shift right). After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit and evaluate ok = ^{shift, parity}. Go to STOP.
  - STOP:
    - data=0 → set `frame_err`, no push.
    - else if !ok → set `parity_err`, no push.
    - else push the byte.
    - Always return to IDLE.
- **Watchdog:**
  - The counter clears in IDLE and on every detected edge, and increments otherwise.
  - On reaching `TIMEOUT_CYCLES`-1 in any non-IDLE state: set `frame_err`, discard the partial byte, go to IDLE.
- **FIFO:**
  - Show-ahead: `rd_data` = mem[rptr] combinationally.
  - Pointers are `ADDR_WIDTH`+1 bits, with wrap on the extra bit.
  - pop = `rd_en` & !empty.
  - A push is accepted if !full or pop. Simultaneous push and pop at full leaves `count` unchanged. If neither holds, the byte is dropped and `overflow` is set.
- **Error flags:**
  - `clr_err` clears all three flags.
  - If a set and a `clr_err` occur in the same cycle, set wins.
- **Reset:**
  - `rst` at any time, mid-frame included, forces IDLE, clears the shift register and watchdog, and empties the FIFO.
  - Reset values: all outputs 0. `rd_data` reads 0 because memory is not reset, but `out_valid`=0.

## Timing
- Edge detection latency: `SYNC_STAGES`+1 `clk` cycles after the pin falls.
- Byte availability: the push is registered at the stop-bit detect cycle, and `out_valid`/`count` update one cycle later.
- Pop takes effect next cycle: the next byte appears on `rd_data` the cycle after `rd_en` is sampled.
- `full` and `count` are registered-pointer derived and change only on clk edges.
- Minimum legal `ps2_clk` half-period: `SYNC_STAGES`+2 `clk` cycles. Slower is arbitrary up to the timeout.

## Structure
- Package `ps2_pkg`:
  - `typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;`
  - `PS2_DATA_BITS`=8, `PS2_FRAME_BITS`=11.
- Sub-module `sync_fifo`: single-clock show-ahead FIFO, parametrised by `DATA_WIDTH`/`DATA_DEPTH`/`ADDR_WIDTH`, with push/pop/full/empty/count ports.
- The receive FSM, synchroniser and watchdog live in `ps2_rx_fifo`.

## Test plan
Bench conditions: `ps2_clk` half-period 6 `clk` cycles; default parameters.
- **Good frame:** send frame 0x1C with parity 0 → `out_valid`=1, `rd_data`=0x1C, `count`=1, no flags set. Pulse `rd_en` → `out_valid`=0.
- **Parity error:** send 0x1C with parity 1 → `parity_err`=1, `count`=0. A following good 0xF0 → `rd_data`=0xF0.
- **Bad stop bit:** send 0x5A with stop=0 → `frame_err`=1, no push. `clr_err` → all flags 0.
- **Overflow:** send 9 good frames 0x01..0x09 with no reads → `full`=1 after the 8th, `overflow`=1 after the 9th. Drain → reads 0x01..0x08 in order.
- **Full with simultaneous pop:** with the FIFO full, hold `rd_en`=1 across the stop-bit push of 0x33 → `count` stays 8, `overflow` stays 0, and 0x33 is read last.
- **Timeout and reset:**
  - Stop `ps2_clk` after 4 data bits → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last edge. The next frame 0x12 is received correctly.
  - Assert `rst` mid-frame → all outputs 0, FSM in IDLE. The next frame 0x12 is received correctly.
